// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO and its read-side output stage.
`default_nettype none

package fifo_pkg;

  localparam int DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] fifo_data_t;
  typedef logic [1:0]            fifo_occ_t;

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_fwft_out.sv
// fifo_fwft_out: FIFO read-side stage presenting data as a first-word-fall-through
// valid/ready stream through a two-entry (head + skid) holding buffer.
`default_nettype none

module fifo_fwft_out
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output fifo_occ_t             occ
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  head_v_q, head_v_d;
  logic                  skid_v_q, skid_v_d;
  logic                  inflight_q;

  logic       pop;
  logic       head_v_pp;
  logic       skid_v_pp;
  logic       overflow;
  logic [2:0] level;

  assign m_valid = head_v_q;
  assign m_data  = head_q;

  always_comb begin
    pop       = head_v_q & m_ready;
    occ       = {1'b0, head_v_q} + {1'b0, skid_v_q};
    // Words committed after this cycle's pop, counting the read already in flight.
    level     = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd   = reset_n & ~fifo_empty & (level < 3'd2);

    head_v_pp = pop ? skid_v_q : head_v_q;
    skid_v_pp = skid_v_q & ~pop;
    overflow  = inflight_q & head_v_pp & skid_v_pp;

    head_d    = pop ? skid_q : head_q;
    head_v_d  = head_v_pp;
    skid_d    = skid_q;
    skid_v_d  = skid_v_pp;

    if (inflight_q) begin
      if (!head_v_pp) begin
        head_d   = fifo_rdata;
        head_v_d = 1'b1;
      end else begin
        skid_d   = fifo_rdata;
        skid_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_v_q   <= head_v_d;
      skid_v_q   <= skid_v_d;
      inflight_q <= fifo_rd;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n) !overflow);

endmodule : fifo_fwft_out

`default_nettype wire

// File: tb/tb_fifo_fwft_out.sv
// Directed self-checking bench for fifo_fwft_out with a behavioural FIFO read port.
`default_nettype none

module tb_fifo_fwft_out;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_rdata;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] occ;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] mem [0:31];
  logic [4:0] wptr;
  logic [4:0] rptr;

  always #5 clk = ~clk;

  assign fifo_empty = (wptr == rptr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr       <= '0;
      fifo_rdata <= '0;
    end else if (fifo_rd) begin
      fifo_rdata <= mem[rptr];
      rptr       <= rptr + 5'd1;
    end
  end

  fifo_fwft_out #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .occ        (occ)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    mem[wptr] = w;
    wptr      = wptr + 5'd1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_ready = 1'b0;
    wptr    = '0;
    #2;
    tests_run++;
    if ({m_valid, occ, fifo_rd} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid/occ/rd=%b required 0000", {m_valid, occ, fifo_rd});
    end
    tests_run++;
    if (m_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data: m_data=%h required 00", m_data);
    end
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      settle();
      tests_run++;
      if ({m_valid, occ, fifo_rd} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_idle c%0d: valid/occ/rd=%b required 0000", c, {m_valid, occ, fifo_rd});
      end
    end
  endtask

  task automatic test_single_word();
    m_ready = 1'b1;
    next_cycle();
    push(8'hA5);
    settle();
    tests_run++;
    if ({fifo_rd, m_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_N: rd/valid=%b required 10", {fifo_rd, m_valid});
    end
    next_cycle();
    settle();
    tests_run++;
    if ({fifo_rd, m_valid, occ} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_N1: rd/valid/occ=%b required 0000", {fifo_rd, m_valid, occ});
    end
    next_cycle();
    settle();
    tests_run++;
    if ({m_valid, occ, m_data} !== {1'b1, 2'd1, 8'hA5}) begin
      tests_failed++;
      $display("FAIL single_N2: valid=%b occ=%0d data=%h required 1 1 a5", m_valid, occ, m_data);
    end
    next_cycle();
    settle();
    tests_run++;
    if ({m_valid, occ} !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_pop: valid=%b occ=%0d required 0 0", m_valid, occ);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] exp_d;
    m_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 8; i++) push(8'(i));
    settle();
    for (int c = 0; c < 12; c++) begin
      tests_run++;
      if (fifo_rd !== (c < 8)) begin
        tests_failed++;
        $display("FAIL stream_rd c%0d: fifo_rd=%b required %b", c, fifo_rd, (c < 8));
      end
      tests_run++;
      if (m_valid !== (c >= 2 && c < 10)) begin
        tests_failed++;
        $display("FAIL stream_valid c%0d: m_valid=%b required %b", c, m_valid, (c >= 2 && c < 10));
      end
      if (c >= 2 && c < 10) begin
        exp_d = 8'(c - 2);
        tests_run++;
        if (m_data !== exp_d) begin
          tests_failed++;
          $display("FAIL stream_data c%0d: m_data=%h required %h", c, m_data, exp_d);
        end
      end
      next_cycle();
      settle();
    end
  endtask

  task automatic test_back_pressure();
    int         rd_pulses;
    logic [7:0] exp_d;
    m_ready = 1'b0;
    next_cycle();
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    settle();
    rd_pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (fifo_rd) rd_pulses++;
      next_cycle();
      settle();
    end
    tests_run++;
    if (rd_pulses != 2) begin
      tests_failed++;
      $display("FAIL bp_rd_pulses: counted %0d required 2", rd_pulses);
    end
    tests_run++;
    if ({occ, m_valid, m_data} !== {2'd2, 1'b1, 8'h10}) begin
      tests_failed++;
      $display("FAIL bp_hold: occ=%0d valid=%b data=%h required 2 1 10", occ, m_valid, m_data);
    end
    m_ready = 1'b1;
    settle();
    tests_run++;
    if (fifo_rd !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_rd_reassert: fifo_rd=%b required 1", fifo_rd);
    end
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (m_valid !== (c < 4)) begin
        tests_failed++;
        $display("FAIL bp_release_valid c%0d: m_valid=%b required %b", c, m_valid, (c < 4));
      end
      if (c < 4) begin
        exp_d = 8'h10 + 8'(c);
        tests_run++;
        if (m_data !== exp_d) begin
          tests_failed++;
          $display("FAIL bp_release_data c%0d: m_data=%h required %h", c, m_data, exp_d);
        end
      end
      next_cycle();
      settle();
    end
  endtask

  task automatic test_alternating_ready();
    int         idx;
    logic       stalled;
    logic [7:0] held;
    logic [7:0] exp_d;
    idx     = 0;
    stalled = 1'b0;
    held    = '0;
    next_cycle();
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    for (int c = 0; c < 60; c++) begin
      m_ready = c[0];
      settle();
      if (stalled) begin
        tests_run++;
        if ({m_valid, m_data} !== {1'b1, held}) begin
          tests_failed++;
          $display("FAIL alt_hold c%0d: valid=%b data=%h required 1 %h", c, m_valid, m_data, held);
        end
      end
      if (m_valid && m_ready) begin
        exp_d = 8'h20 + 8'(idx);
        tests_run++;
        if (m_data !== exp_d) begin
          tests_failed++;
          $display("FAIL alt_order idx%0d: m_data=%h required %h", idx, m_data, exp_d);
        end
        idx++;
      end
      stalled = m_valid & ~m_ready;
      held    = m_data;
      next_cycle();
    end
    settle();
    tests_run++;
    if (idx != 16 || m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL alt_count: delivered %0d valid=%b required 16 0", idx, m_valid);
    end
  endtask

  task automatic test_drain_empty();
    logic [7:0] exp_d;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
    settle();
    for (int c = 0; c < 7; c++) begin
      tests_run++;
      if (fifo_rd !== (c < 3)) begin
        tests_failed++;
        $display("FAIL drain_rd c%0d: fifo_rd=%b required %b", c, fifo_rd, (c < 3));
      end
      tests_run++;
      if (m_valid !== (c >= 2 && c <= 4)) begin
        tests_failed++;
        $display("FAIL drain_valid c%0d: m_valid=%b required %b", c, m_valid, (c >= 2 && c <= 4));
      end
      if (c >= 2 && c <= 4) begin
        exp_d = 8'h30 + 8'(c - 2);
        tests_run++;
        if (m_data !== exp_d) begin
          tests_failed++;
          $display("FAIL drain_data c%0d: m_data=%h required %h", c, m_data, exp_d);
        end
      end
      next_cycle();
      settle();
    end
  endtask

  task automatic test_reset_mid_transfer();
    m_ready = 1'b0;
    next_cycle();
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    for (int c = 0; c < 4; c++) next_cycle();
    settle();
    tests_run++;
    if ({occ, m_valid} !== {2'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL rstmid_pre: occ=%0d valid=%b required 2 1", occ, m_valid);
    end
    #1;
    reset_n = 1'b0;
    wptr    = '0;
    #1;
    tests_run++;
    if ({m_valid, occ, fifo_rd, m_data} !== 12'h000) begin
      tests_failed++;
      $display("FAIL rstmid_async: valid=%b occ=%0d rd=%b data=%h required all 0", m_valid, occ, fifo_rd, m_data);
    end
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      settle();
      tests_run++;
      if ({m_valid, occ, fifo_rd} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL rstmid_after c%0d: valid/occ/rd=%b required 0000", c, {m_valid, occ, fifo_rd});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_back_pressure();
    test_alternating_ready();
    test_drain_empty();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_fifo_fwft_out

`default_nettype wire

// File: doc/fifo_fwft_out.md
# fifo_fwft_out

Read-side output stage placed directly downstream of the synchronous FIFO controller and its register file. It drives the FIFO's `rd` strobe from the FIFO's `empty` flag, captures the registered read data, and presents it to a consumer over a valid/ready stream in first-word-fall-through style. A two-entry holding buffer (head + skid) sustains one word per cycle and absorbs consumer back-pressure without losing the read that is already in flight.

## Interface
- `DATA_WIDTH`, default 8: width of FIFO read data and stream data.
- `clk`  in  1  rising-edge clock shared with the FIFO.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  registered empty flag from the FIFO controller.
- `fifo_rd`  out  1  read strobe to the FIFO controller. The controller's write input is not driven by this block.
- `fifo_rdata`  in  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_rd`.
- `m_valid`  out  1  head word present.
- `m_ready`  in  1  consumer accepts the head word.
- `m_data`  out  DATA_WIDTH  head word.
- `occ`  out  2  words held in the buffer, 0..2. This count excludes the in-flight read.

## Operation
- State is:
  - `head`, `skid` data registers.
  - `head_v`, `skid_v` valid bits.
  - `inflight` (1 bit): registered copy of `fifo_rd`.
- Occupancy rules:
  - `occ = head_v + skid_v`.
  - `pop = m_valid & m_ready`.
- `fifo_rd = ~fifo_empty & (occ + inflight - pop < 2)`. It is combinational and is never asserted while `fifo_empty` is 1.
- Capture happens when `inflight` = 1: `fifo_rdata` is written into the buffer in that cycle.
- Update rules per cycle, applied in order:
  - On pop: `head <= skid` and `head_v <= skid_v`, then `skid_v <= 0`.
  - On capture, the word goes to the lowest free slot after the pop: `head` if `head_v` is 0 after the pop, otherwise `skid`.
  - Overflow is impossible by construction. An assertion must check that capture never happens with both slots full after the pop.
- `m_valid = head_v` and `m_data = head`, both driven straight from registers.
- Word order out of the block equals FIFO read order in every case.

## Timing
- Reset (async assert, sync deassert handled at system level):
  - `head_v`, `skid_v`, `inflight` = 0.
  - `head`, `skid` = 0.
  - Outputs: `m_valid` = 0, `m_data` = 0, `occ` = 0, `fifo_rd` = 0 while `reset_n` is low.
- Latency: if `fifo_empty` falls in cycle N with the buffer empty:
  - `fifo_rd` = 1 in cycle N.
  - Data is captured at the end of N+1.
  - `m_valid` = 1 from N+2.
- Throughput: 1 word/cycle sustained while the FIFO is non-empty and `m_ready` = 1.
- Back-pressure: with `m_ready` = 0, at most 2 words are read, then `fifo_rd` stays 0.
  - After `m_ready` rises, the head pops in that cycle.
  - `fifo_rd` may reassert in the same cycle.
- Handshake: `m_data` is held stable while `m_valid` = 1 and `m_ready` = 0. `m_valid` never drops without a pop.
- FIFO empty: `fifo_rd` = 0, and buffered words continue to drain.
- Simultaneous pop and capture with `occ` = 1: the captured word lands in `head`, and `occ` stays 1.
- Reset mid-transfer: buffered and in-flight words are discarded. The FIFO pointers are reset by the same system reset, so no stale read is captured afterwards.

## Structure
- The shared package `fifo_pkg` holds:
  - `DATA_WIDTH` default.
  - `typedef logic [DATA_WIDTH-1:0] fifo_data_t`.
  - `typedef logic [1:0] fifo_occ_t`.
- The block is a single flat module with no sub-module. The datapath is two registers plus a mux, which is too small to justify one.
- The top-level FIFO wrapper instantiates this block beside the controller and register file.

## Test plan
- **Reset:** drive `reset_n` = 0 mid-stream with `occ` = 2 → `m_valid`, `occ`, `fifo_rd` all go to 0 immediately. After release with FIFO empty, they stay 0.
- **Single word:** write 0xA5 into the empty FIFO, `m_ready` = 1 → `fifo_rd` pulses once in the cycle `fifo_empty` falls. `m_valid` rises with `m_data` = 0xA5 two cycles later, and pops in one cycle.
- **Streaming:** preload 8 words 0x00..0x07, hold `m_ready` = 1 → after the initial 2-cycle latency, 8 consecutive `m_valid` cycles in order. `fifo_rd` is high for 8 consecutive cycles.
- **Back-pressure:** preload 4 words, hold `m_ready` = 0 → exactly 2 `fifo_rd` pulses, `occ` = 2, `m_data` held at word 0. Release → words 0..3 in order with no gap after the first pop.
- **Alternating ready:** `m_ready` toggles every cycle over 16 words → every word is delivered once, in order. The overflow assertion never fires.
- **Drain at empty:** write 3 words with `m_ready` = 1 → after the third read `fifo_empty` = 1 and `fifo_rd` stays 0. `m_valid` deasserts after the last pop.
